// File: rtl/tm1637_frame_controller.sv
// tm1637_frame_controller
//   Drives a TM1637 LED driver. Digit writes update a shadow buffer. A commit
//   copies that buffer into a frame buffer and transmits one frame of three bus
//   transactions:
//     40h
//     C0h, digit0 .. digit(NUM_DIGITS-1)
//     80h | display_on<<3 | brightness
//   Every byte goes out LSB first and is followed by an ACK slot.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data   shadow-buffer write port (addr >= NUM_DIGITS ignored)
//   brightness, display_on  display-control fields, sampled at frame start
//   commit              transmission request pulse
//   busy                frame in progress (includes a queued follow-up frame)
//   frame_done          one-cycle pulse on the tick ending the last STOP
//   ack_error           sticky NACK flag, cleared when a frame starts
//   tm_clk              bus clock, 1 = released
//   tm_dio_oe           1 = pull DIO low
//   tm_dio_in           DIO pad level (asynchronous, synchronised here)
//   state_dbg           current FSM state for debug/observation
//
// Handshake: commit and wr_en are single-cycle strobes with no back-pressure.
// A commit is never lost. In IDLE it starts a frame on the next edge. While busy
// it is remembered as "pending" and served right after the current frame.
module tm1637_frame_controller #(
    parameter int CLK_DIV    = 250,
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_RST = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] brightness,
    input  logic       display_on,
    input  logic       commit,
    output logic       busy,
    output logic       frame_done,
    output logic       ack_error,
    output logic       tm_clk,
    output logic       tm_dio_oe,
    input  logic       tm_dio_in,
    output logic [2:0] state_dbg
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_BIT    = 3'd2;
    localparam logic [2:0] S_ACK    = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_RELOAD = 3'd5;  // one cycle between back-to-back frames

    logic [2:0]    state;
    logic [1:0]    phase;      // tick slot within the current state
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;   // byte within the current transaction
    logic [1:0]    txn;        // 0: data cmd, 1: address + digits, 2: display ctrl
    logic [PW-1:0] prescaler;
    logic          tick;
    logic          start_frame;
    logic          last_byte;
    logic          pending;
    logic          ack_chk;    // the next tick ends an ACK high phase
    logic [7:0]    shadow    [NUM_DIGITS];
    logic [7:0]    frame_buf [NUM_DIGITS];
    logic [2:0]    bright_q;
    logic          disp_q;
    logic          dio_meta;
    logic          dio_sync;
    logic [7:0]    digit_byte;
    logic [7:0]    cur_byte;

    assign busy        = (state != S_IDLE);
    assign state_dbg   = state;
    assign tick        = (prescaler == PW'(CLK_DIV - 1));
    assign start_frame = ((state == S_IDLE) && commit) || (state == S_RELOAD);
    assign last_byte   = (txn != 2'd1) || (byte_idx == 3'(NUM_DIGITS));

    // Byte currently being shifted out.
    always_comb begin
        digit_byte = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (byte_idx == 3'(i + 1)) digit_byte = frame_buf[i];
        end
        case (txn)
            2'd0:    cur_byte = 8'h40;
            2'd1:    cur_byte = (byte_idx == 3'd0) ? 8'hC0 : digit_byte;
            default: cur_byte = {4'h8, disp_q, bright_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dio_meta <= 1'b1;
            dio_sync <= 1'b1;
        end else begin
            dio_meta <= tm_dio_in;
            dio_sync <= dio_meta;
        end
    end

    // The shadow buffer accepts writes at any time. Only frame start reads it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= 8'h00;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_addr == 3'(i)) shadow[i] <= wr_data;
            end
        end
    end

    // Each tick applies the bus levels of the slot named by (state, phase) and
    // then advances. The frame therefore ends on the tick that releases DIO
    // after the final STOP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            phase      <= 2'd0;
            bit_idx    <= 3'd0;
            byte_idx   <= 3'd0;
            txn        <= 2'd0;
            prescaler  <= '0;
            tm_clk     <= 1'b1;
            tm_dio_oe  <= 1'b0;
            frame_done <= 1'b0;
            ack_error  <= 1'b0;
            ack_chk    <= 1'b0;
            pending    <= 1'b0;
            bright_q   <= 3'(BRIGHT_RST);
            disp_q     <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) frame_buf[i] <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            if (state == S_RELOAD) pending <= 1'b0;
            if (commit && (state != S_IDLE)) pending <= 1'b1;

            if (start_frame) begin
                for (int i = 0; i < NUM_DIGITS; i++) frame_buf[i] <= shadow[i];
                bright_q  <= brightness;
                disp_q    <= display_on;
                ack_error <= 1'b0;
                ack_chk   <= 1'b0;
                state     <= S_START;
                phase     <= 2'd0;
                txn       <= 2'd0;
                byte_idx  <= 3'd0;
                bit_idx   <= 3'd0;
                prescaler <= '0;
            end else if (state != S_IDLE) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick) begin
                    if (ack_chk) begin
                        ack_chk <= 1'b0;
                        if (dio_sync) ack_error <= 1'b1;
                    end
                    case (state)
                        S_START: begin
                            if (phase == 2'd0) begin
                                tm_dio_oe <= 1'b1;
                                phase     <= 2'd1;
                            end else begin
                                tm_clk  <= 1'b0;
                                phase   <= 2'd0;
                                bit_idx <= 3'd0;
                                state   <= S_BIT;
                            end
                        end
                        S_BIT: begin
                            if (phase == 2'd0) begin
                                tm_clk    <= 1'b0;
                                tm_dio_oe <= ~cur_byte[bit_idx];
                                phase     <= 2'd1;
                            end else begin
                                tm_clk <= 1'b1;
                                phase  <= 2'd0;
                                if (bit_idx == 3'd7) state <= S_ACK;
                                else bit_idx <= bit_idx + 3'd1;
                            end
                        end
                        S_ACK: begin
                            if (phase == 2'd0) begin
                                tm_clk    <= 1'b0;
                                tm_dio_oe <= 1'b0;
                                phase     <= 2'd1;
                            end else begin
                                tm_clk  <= 1'b1;
                                ack_chk <= 1'b1;
                                phase   <= 2'd0;
                                if (last_byte) begin
                                    state <= S_STOP;
                                end else begin
                                    byte_idx <= byte_idx + 3'd1;
                                    bit_idx  <= 3'd0;
                                    state    <= S_BIT;
                                end
                            end
                        end
                        S_STOP: begin
                            if (phase == 2'd0) begin
                                tm_clk    <= 1'b0;
                                tm_dio_oe <= 1'b1;
                                phase     <= 2'd1;
                            end else if (phase == 2'd1) begin
                                tm_clk <= 1'b1;
                                phase  <= 2'd2;
                            end else begin
                                tm_dio_oe <= 1'b0;
                                phase     <= 2'd0;
                                if (txn == 2'd2) begin
                                    frame_done <= 1'b1;
                                    // A commit arriving on this very cycle also counts as pending.
                                    state <= (pending || commit) ? S_RELOAD : S_IDLE;
                                end else begin
                                    txn      <= txn + 2'd1;
                                    byte_idx <= 3'd0;
                                    state    <= S_START;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tm1637_frame_controller.sv
module tb_tm1637_frame_controller;

    localparam int CLK_DIV     = 2;
    localparam int NUM_DIGITS  = 4;
    localparam int FRAME_TICKS = 3 * (2 + 3) + 18 * (NUM_DIGITS + 3);  // 141

    // ---------------- clock / reset / DUT ----------------
    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       wr_en      = 1'b0;
    logic [2:0] wr_addr    = 3'd0;
    logic [7:0] wr_data    = 8'h00;
    logic [2:0] brightness = 3'd0;
    logic       display_on = 1'b0;
    logic       commit     = 1'b0;
    logic       busy, frame_done, ack_error, tm_clk, tm_dio_oe, tm_dio_in;
    logic [2:0] state_dbg;
    logic       pull = 1'b0;   // responder pulling DIO low
    logic       dio_line;

    assign dio_line  = ~(tm_dio_oe | pull);
    assign tm_dio_in = dio_line;

    always #5 clk = ~clk;

    tm1637_frame_controller #(
        .CLK_DIV(CLK_DIV), .NUM_DIGITS(NUM_DIGITS), .BRIGHT_RST(7)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .brightness(brightness), .display_on(display_on),
        .commit(commit), .busy(busy), .frame_done(frame_done),
        .ack_error(ack_error), .tm_clk(tm_clk), .tm_dio_oe(tm_dio_oe),
        .tm_dio_in(tm_dio_in), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int         tests  = 0;
    int         failed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bytes(input string name);
        check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size()) check($sformatf("%s_byte%0d", name, k), 64'(got_q[k]), 64'(exp_q[k]));
        end
        exp_q.delete();
    endtask

    // ---------------- bus decoder, ACK responder, protocol monitor ----------------
    int         cyc       = 0;
    int         ref_cyc   = 0;
    int         viol      = 0;
    int         nack_idx  = -1;   // frame byte index to leave un-ACKed
    int         bitcnt    = 0;
    logic [7:0] shreg     = 8'h00;
    logic       prev_clk  = 1'b1;
    logic       prev_dio  = 1'b1;
    logic       prev_oe   = 1'b0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            bitcnt    = 0;
            pull      = 1'b0;
            prev_clk  = 1'b1;
            prev_dio  = 1'b1;
            prev_oe   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) ref_cyc = cyc;
            // Bus lines may move only on tick boundaries.
            if ((busy || frame_done) && ((tm_clk != prev_clk) || (tm_dio_oe != prev_oe))
                && (((cyc - ref_cyc) % CLK_DIV) != 0)) viol++;
            if (frame_done) ref_cyc = cyc + 1;

            if (prev_clk && tm_clk && prev_dio && !dio_line) begin
                bitcnt = 0;                              // START
            end else if (prev_clk && tm_clk && !prev_dio && dio_line) begin
                bitcnt = 0;                              // STOP
            end else if (!prev_clk && tm_clk) begin
                if (bitcnt < 8) begin
                    shreg[bitcnt] = dio_line;
                    bitcnt++;
                end else begin
                    got_q.push_back(shreg);              // 9th clock = ACK
                    bitcnt = 0;
                end
            end else if (prev_clk && !tm_clk) begin
                pull = (bitcnt == 8) && (got_q.size() != nack_idx);
            end
            prev_clk  = tm_clk;
            prev_dio  = ~(tm_dio_oe | pull);
            prev_oe   = tm_dio_oe;
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_digit(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic wait_frames(input int nframes, output int busy_cyc, output int dones,
                               output bit idle_gap, output bit timed_out);
        busy_cyc = 0; dones = 0; idle_gap = 0; timed_out = 1;
        for (int i = 0; i < 4000; i++) begin
            if (busy) busy_cyc++;
            if (frame_done) dones++;
            if (dones == nframes) begin
                timed_out = 0;
                break;
            end
            if (!busy) idle_gap = 1;
            @(negedge clk);
        end
    endtask

    task automatic settle_check(input string name);
        int extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_done) extra++;
        end
        check({name, "_extra_done"}, 64'(extra), 64'd0);
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] digits;   // digit0 in [7:0]
        logic [2:0]  bright;
        logic        on;
        int          nack;
        logic [55:0] exp;      // first bus byte in [55:48]
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int bc, dn;
        bit gap, to, found;

        vecs[0] = '{32'h4F5B063F, 3'd3, 1'b1, -1, 56'h40C03F065B4F8B, 1'b0};
        vecs[1] = '{32'h4F5B063F, 3'd3, 1'b1,  4, 56'h40C03F065B4F8B, 1'b1};
        vecs[2] = '{32'h7E81FF00, 3'd0, 1'b0, -1, 56'h40C000FF817E80, 1'b0};
        vecs[3] = '{32'h8001AA55, 3'd5, 1'b1,  6, 56'h40C055AA01808D, 1'b1};
        vecs[4] = '{32'h78563412, 3'd7, 1'b0,  0, 56'h40C01234567887, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tm_clk", 64'(tm_clk), 64'd1);
        check("rst_oe", 64'(tm_dio_oe), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_ack_error", 64'(ack_error), 64'd0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            for (int d = 0; d < 4; d++) write_digit(3'(d), vecs[v].digits[8*d +: 8]);
            brightness = vecs[v].bright;
            display_on = vecs[v].on;
            nack_idx   = vecs[v].nack;
            if (v > 0) check($sformatf("v%0d_ack_sticky", v), 64'(ack_error), 64'(vecs[v-1].exp_err));
            got_q.delete();
            for (int k = 0; k < 7; k++) exp_q.push_back(vecs[v].exp[8*(6-k) +: 8]);
            pulse_commit();
            wait_frames(1, bc, dn, gap, to);
            check($sformatf("v%0d_timeout", v), 64'(to), 64'd0);
            check($sformatf("v%0d_busy_cycles", v), 64'(bc), 64'(FRAME_TICKS * CLK_DIV));
            check($sformatf("v%0d_ack_error", v), 64'(ack_error), 64'(vecs[v].exp_err));
            check_bytes($sformatf("v%0d", v));
            settle_check($sformatf("v%0d", v));
        end

        // Mid-frame write and commit: the old digit0 goes out, then a second frame carries 7F
        brightness = 3'd3; display_on = 1'b1; nack_idx = -1;
        write_digit(3'd0, 8'h3F); write_digit(3'd1, 8'h06);
        write_digit(3'd2, 8'h5B); write_digit(3'd3, 8'h4F);
        got_q.delete();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(8'h40); exp_q.push_back(8'hC0);
            exp_q.push_back(k == 0 ? 8'h3F : 8'h7F);
            exp_q.push_back(8'h06); exp_q.push_back(8'h5B); exp_q.push_back(8'h4F);
            exp_q.push_back(8'h8B);
        end
        pulse_commit();
        repeat (10) @(negedge clk);
        write_digit(3'd0, 8'h7F);
        pulse_commit();
        wait_frames(2, bc, dn, gap, to);
        check("mid_timeout", 64'(to), 64'd0);
        check("mid_done_pulses", 64'(dn), 64'd2);
        check("mid_idle_gap", 64'(gap), 64'd0);
        check_bytes("mid");
        settle_check("mid");

        // Out-of-range writes are ignored
        write_digit(3'd5, 8'hFF);
        write_digit(3'd4, 8'hFF);
        got_q.delete();
        exp_q.push_back(8'h40); exp_q.push_back(8'hC0); exp_q.push_back(8'h7F);
        exp_q.push_back(8'h06); exp_q.push_back(8'h5B); exp_q.push_back(8'h4F);
        exp_q.push_back(8'h8B);
        pulse_commit();
        wait_frames(1, bc, dn, gap, to);
        check("oor_timeout", 64'(to), 64'd0);
        check_bytes("oor");

        // Reset while the third digit is on the bus, with CLK low and DIO pulled
        pulse_commit();
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ((got_q.size() >= 11) && !tm_clk && tm_dio_oe) begin
                found = 1;
                break;
            end
        end
        check("rstmid_reached", 64'(found), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_tm_clk", 64'(tm_clk), 64'd1);
        check("rstmid_oe", 64'(tm_dio_oe), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        brightness = 3'd7; display_on = 1'b1;
        got_q.delete();
        exp_q.push_back(8'h40); exp_q.push_back(8'hC0);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h8F);
        pulse_commit();
        wait_frames(1, bc, dn, gap, to);
        check("post_rst_timeout", 64'(to), 64'd0);
        check("post_rst_busy_cycles", 64'(bc), 64'(FRAME_TICKS * CLK_DIV));
        check("post_rst_ack_error", 64'(ack_error), 64'd0);
        check_bytes("post_rst");
        settle_check("post_rst");

        check("protocol_violations", 64'(viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
